md_ctrl: RTL and testbench

Sequencer for the shared multiply/divide resource used by the EX stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation from EX and latches its operands. It drives the external pipelined multiplier and the iterative divider, and holds EX via stallreq until the result is ready. It owns the HI/LO architectural registers and writes them on completion.

---
 rtl/md_ctrl_pkg.sv | 34 +++
 rtl/md_ctrl_hilo_reg.sv | 35 +++
 rtl/md_ctrl.sv | 151 +++++++++++++++
 tb/tb_md_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states and
// the named levels used on the stall and divider interfaces.
package md_ctrl_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DONE     = 2'd3
  } md_state_e;

  localparam logic Stop              = 1'b1;
  localparam logic NoStop            = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl_hilo_reg.sv
// HI/LO architectural register pair. Define MD_HILO_BYPASS_EN to make the read
// ports return the value being written in the same cycle.
module md_ctrl_hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] hi_wdata_i,
  input  logic [31:0] lo_wdata_i,
  output logic [31:0] hi_rdata_o,
  output logic [31:0] lo_rdata_o
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (hi_we_i) hi_q <= hi_wdata_i;
      if (lo_we_i) lo_q <= lo_wdata_i;
    end
  end

`ifdef MD_HILO_BYPASS_EN
  assign hi_rdata_o = hi_we_i ? hi_wdata_i : hi_q;
  assign lo_rdata_o = lo_we_i ? lo_wdata_i : lo_q;
`else
  assign hi_rdata_o = hi_q;
  assign lo_rdata_o = lo_q;
`endif

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for EX: drives the pipelined multiplier and the
// iterative divider, stalls EX until done, owns HI/LO (bypass: MD_HILO_BYPASS_EN).
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_LAT     = 2,
  parameter int DIV_MAX_CYC = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        done,
  output logic        err,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [1:0]  dbg_state_o
);

  localparam int WD_W = $clog2(DIV_MAX_CYC + 1);

  md_state_e       state_q;
  logic [2:0]      cnt_q;
  logic [WD_W-1:0] wd_q;
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic            signed_q;
  logic            done_q;

  logic idle_op, mul_go, div_go, div_zero, mt_hi, mt_lo, in_wait;
  logic mul_cap, div_cap, wd_abort, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  // Handshake: EX presents op_valid with operands and must hold the same
  // instruction while stallreq is high and during the following DONE cycle;
  // the operation is accepted in the IDLE cycle where op_valid is seen.
  assign idle_op  = !rst && !flush && (state_q == S_IDLE) && op_valid;
  assign mul_go   = idle_op && is_mul(op_code);
  assign div_go   = idle_op && is_div(op_code) && (src_b != 32'd0);
  assign div_zero = idle_op && is_div(op_code) && (src_b == 32'd0);
  assign mt_hi    = idle_op && (op_code == OP_MTHI);
  assign mt_lo    = idle_op && (op_code == OP_MTLO);
  assign in_wait  = (state_q == S_MUL_WAIT) || (state_q == S_DIV_WAIT);

  assign mul_cap  = !rst && !flush && (state_q == S_MUL_WAIT) && (cnt_q == 3'd1);
  assign div_cap  = !rst && !flush && (state_q == S_DIV_WAIT) && (div_ready == DivResultReady);
  assign wd_abort = !rst && !flush && (state_q == S_DIV_WAIT) && (div_ready == DivResultNotReady)
                    && (wd_q == WD_W'(DIV_MAX_CYC - 1));

  assign stallreq = (mul_go || div_go || (!rst && !flush && in_wait)) ? Stop : NoStop;
  assign err      = div_zero || wd_abort;
  assign done     = done_q;
  assign div_annul = !rst && (state_q == S_DIV_WAIT) && (flush || wd_abort);
  assign div_start = (!rst && !flush && !wd_abort && (state_q == S_DIV_WAIT)
                      && (div_ready == DivResultNotReady)) ? DivStart : DivStop;

  // Both units see only the operands latched at acceptance.
  assign mul_signed  = signed_q;
  assign mul_ina     = op_a_q;
  assign mul_inb     = op_b_q;
  assign div_signed  = signed_q;
  assign div_op1     = op_a_q;
  assign div_op2     = op_b_q;
  assign dbg_state_o = state_q;

  assign hi_we    = mt_hi || mul_cap || div_cap;
  assign lo_we    = mt_lo || mul_cap || div_cap;
  assign hi_wdata = mul_cap ? mul_result[63:32] : (div_cap ? div_result[63:32] : src_a);
  assign lo_wdata = mul_cap ? mul_result[31:0]  : (div_cap ? div_result[31:0]  : src_a);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      wd_q     <= '0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (mul_go) begin
              state_q  <= S_MUL_WAIT;
              cnt_q    <= 3'(MUL_LAT);
              op_a_q   <= src_a;
              op_b_q   <= src_b;
              signed_q <= (op_code == OP_MULT);
            end else if (div_go) begin
              state_q  <= S_DIV_WAIT;
              wd_q     <= '0;
              op_a_q   <= src_a;
              op_b_q   <= src_b;
              signed_q <= (op_code == OP_DIV);
            end
          end
          S_MUL_WAIT: begin
            cnt_q <= cnt_q - 3'd1;
            if (mul_cap) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
          S_DIV_WAIT: begin
            if (div_cap) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (wd_abort) begin
              state_q <= S_DONE;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  md_ctrl_hilo_reg u_hilo (
    .clk        (clk),
    .rst        (rst),
    .hi_we_i    (hi_we),
    .lo_we_i    (lo_we),
    .hi_wdata_i (hi_wdata),
    .lo_wdata_i (lo_wdata),
    .hi_rdata_o (hi_rdata),
    .lo_rdata_o (lo_rdata)
  );

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with behavioural multiplier and divider models;
// same-cycle HI/LO expectations follow MD_HILO_BYPASS_EN.
module tb_md_ctrl;

  localparam int MUL_LAT     = 2;
  localparam int DIV_MAX_CYC = 40;
`ifdef MD_HILO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk, rst, op_valid, flush;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        stallreq, done, err;
  logic [31:0] hi_rdata, lo_rdata;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_annul, div_signed, div_ready;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result;
  logic [1:0]  dbg_state;

  md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_MAX_CYC(DIV_MAX_CYC)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stallreq(stallreq),
    .done(done), .err(err), .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start), .div_annul(div_annul),
    .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
    .div_ready(div_ready), .div_result(div_result), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- external unit models ----------------
  logic [63:0] mul_p;
  always @(posedge clk)
    mul_p <= {{32{mul_signed & mul_ina[31]}}, mul_ina} * {{32{mul_signed & mul_inb[31]}}, mul_inb};
  assign mul_result = mul_p;

  int dv_cnt;
  int div_ready_after;
  logic div_model_en;
  always @(posedge clk) begin
    if (rst || !div_start) dv_cnt <= 0;
    else                   dv_cnt <= dv_cnt + 1;
  end
  assign div_ready = div_model_en && (dv_cnt == div_ready_after);

  always_comb begin
    logic signed [31:0] sq, sr;
    div_result = 64'd0;
    sq = 32'sd0;
    sr = 32'sd0;
    if (div_op2 != 32'd0) begin
      if (div_signed) begin
        sq = $signed(div_op1) / $signed(div_op2);
        sr = $signed(div_op1) % $signed(div_op2);
        div_result = {sr, sq};
      end else begin
        div_result = {div_op1 % div_op2, div_op1 / div_op2};
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; holds the op through stall and the first
  // non-stalled cycle, then releases op_valid.
  task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic done_s, output logic err_s,
                       output logic annul_s, output int err_at,
                       output logic [31:0] hi_s, output logic [31:0] lo_s);
    op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
    stalls = 0; err_s = 1'b0; annul_s = 1'b0; err_at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (err && !err_s) begin err_s = 1'b1; err_at = n; end
      if (div_annul) annul_s = 1'b1;
      if (!stallreq) break;
      stalls++;
      @(posedge clk); #1;
    end
    done_s = done; hi_s = hi_rdata; lo_s = lo_rdata;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  int st, ea;
  logic dn, er, an;
  logic [31:0] hs, ls;

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; src_a = 32'd0; src_b = 32'd0;
    flush = 1'b0; div_model_en = 1'b1; div_ready_after = 33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stallreq, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_hilo", {hi_rdata, lo_rdata}, 64'd0);
    check("rst_div_ctl", {div_start, div_annul}, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // MULT 3 * -2 = -6
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    do_op(3'd0, 32'd3, 32'hFFFFFFFE, st, dn, er, an, ea, hs, ls);
    check("mult_stall", st, MUL_LAT + 1);
    check("mult_done", dn, 1);
    check("mult_err", er, 0);
    check("mult_hilo", {hs, ls}, exp_q.pop_front());

    // MULTU 0xFFFFFFFF * 2
    exp_q.push_back(64'h00000001_FFFFFFFE);
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, st, dn, er, an, ea, hs, ls);
    check("multu_stall", st, 3);
    check("multu_done", dn, 1);
    check("multu_hilo", {hs, ls}, exp_q.pop_front());

    // DIV -7 / 2: ready in the 34th DIV_WAIT cycle, stall = 1 + 34
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    div_ready_after = 33;
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, st, dn, er, an, ea, hs, ls);
    check("div_stall", st, 35);
    check("div_done", dn, 1);
    check("div_err", er, 0);
    check("div_hilo", {hs, ls}, exp_q.pop_front());
    @(negedge clk);
    check("div_no_restart", stallreq, 0);
    check("div_no_restart_start", div_start, 0);
    @(posedge clk); #1;

    // DIVU 10 / 0: error pulse, no stall, HI/LO unchanged
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    do_op(3'd3, 32'd10, 32'd0, st, dn, er, an, ea, hs, ls);
    check("divz_stall", st, 0);
    check("divz_err", er, 1);
    check("divz_err_at", ea, 0);
    check("divz_done", dn, 0);
    check("divz_hilo", {hs, ls}, exp_q.pop_front());

    // DIV 100 / 7 flushed in cycle 5
    op_valid = 1'b1; op_code = 3'd2; src_a = 32'd100; src_b = 32'd7;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check("flush_pre_start", div_start, 1);
    check("flush_pre_op1", div_op1, 32'd100);
    check("flush_pre_stall", stallreq, 1);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("flush_annul", div_annul, 1);
    check("flush_stall", stallreq, 0);
    check("flush_err", err, 0);
    @(posedge clk); #1 flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", stallreq, 0);
    check("flush_idle_start", div_start, 0);
    check("flush_hilo", {hi_rdata, lo_rdata}, 64'hFFFFFFFF_FFFFFFFD);
    @(posedge clk); #1;

    exp_q.push_back(64'h00000000_0000001E);
    do_op(3'd0, 32'd5, 32'd6, st, dn, er, an, ea, hs, ls);
    check("post_flush_mult_stall", st, 3);
    check("post_flush_mult_done", dn, 1);
    check("post_flush_mult_hilo", {hs, ls}, exp_q.pop_front());

    // MTHI then MTLO back-to-back
    do_op(3'd4, 32'h12345678, 32'd0, st, dn, er, an, ea, hs, ls);
    check("mthi_stall", st, 0);
    check("mthi_done", dn, 0);
    check("mthi_hi_same", hs, BYPASS ? 32'h12345678 : 32'd0);
    do_op(3'd5, 32'd9, 32'd0, st, dn, er, an, ea, hs, ls);
    check("mtlo_stall", st, 0);
    check("mtlo_hi", hs, 32'h12345678);
    check("mtlo_lo_same", ls, BYPASS ? 32'd9 : 32'h1E);
    @(negedge clk);
    check("mtlo_lo_next", lo_rdata, 32'd9);
    @(posedge clk); #1;

    // MTHI suppressed by a simultaneous flush
    op_valid = 1'b1; op_code = 3'd4; src_a = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clk);
    check("mthi_flush_stall", stallreq, 0);
    check("mthi_flush_hi_same", hi_rdata, 32'h12345678);
    @(posedge clk); #1 op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("mthi_flush_hi_next", hi_rdata, 32'h12345678);
    @(posedge clk); #1;

    // Divider never ready: watchdog abort in DIV_WAIT cycle DIV_MAX_CYC
    div_model_en = 1'b0;
    exp_q.push_back(64'h12345678_00000009);
    do_op(3'd2, 32'd5, 32'd1, st, dn, er, an, ea, hs, ls);
    check("wd_stall", st, DIV_MAX_CYC + 1);
    check("wd_err", er, 1);
    check("wd_err_at", ea, DIV_MAX_CYC);
    check("wd_annul", an, 1);
    check("wd_done", dn, 0);
    check("wd_hilo", {hs, ls}, exp_q.pop_front());
    @(negedge clk);
    check("wd_idle_stall", stallreq, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
